// File: rtl/bus_sync_pkg.sv
// Shared definitions for the CDC bus handshake (transmitter and destination synchronizer).
// Provides the transmitter state encoding and default widths/stage counts.
// Pure declarations; no latency or backpressure of its own.
package bus_sync_pkg;

  // Defaults shared with the destination-side bus synchronizer.
  localparam int BUS_SYNC_BUS_WIDTH     = 8;
  localparam int BUS_SYNC_NUM_OF_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } bus_sync_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset.
// Latency: NUM_OF_STAGES cycles of CLK from d to q.
// No backpressure; samples d every cycle.
//   CLK  in   destination clock for the synchronized bit
//   RST  in   synchronous active-high reset, clears every stage
//   d    in   asynchronous input bit
//   q    out  synchronized output bit
module bit_sync #(
  parameter int NUM_OF_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [NUM_OF_STAGES-1:0] sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '0;
    end else begin
      sync <= {sync[NUM_OF_STAGES-2:0], d};
    end
  end

  assign q = sync[NUM_OF_STAGES-1];

endmodule

// File: rtl/bus_sync_tx.sv
// Source-domain transmitter for the multi-bit CDC bus handshake: launches a held word, then a clean enable pulse.
// Latency: data on unsync_bus one cycle after accept; bus_enable rises one cycle later.
// Backpressure: in_ready only in IDLE; in_valid while not ready is ignored (no buffering).
// Optional feature macro: BUS_SYNC_TX_ACK_EN selects the four-phase ack handshake instead of timed HOLD/GAP.
//   CLK         in   source-domain clock
//   RST         in   synchronous active-high reset (aborts any transfer on that edge)
//   in_data     in   word to send
//   in_valid    in   in_data valid
//   in_ready    out  accept possible; transfer on edge where in_valid && in_ready
//   unsync_bus  out  held data towards the destination (registered)
//   bus_enable  out  level enable towards the destination (registered)
//   bus_ack     in   destination acknowledge, asynchronous; only used in ack mode
//   busy        out  high in every state except IDLE
module bus_sync_tx
  import bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH     = BUS_SYNC_BUS_WIDTH,
  parameter int NUM_OF_STAGES = BUS_SYNC_NUM_OF_STAGES,
  parameter int HOLD_CYCLES   = 8,
  parameter int GAP_CYCLES    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  input  logic                 bus_ack,
  output logic                 busy
);

  bus_sync_state_t      state, state_n;
  logic [BUS_WIDTH-1:0] bus_n;
  logic                 enable_n;

`ifdef BUS_SYNC_TX_ACK_EN
  logic ack_s;

  // Timed-mode parameters have no meaning with the handshake.
  localparam int unused_timing = HOLD_CYCLES + GAP_CYCLES;

  bit_sync #(
    .NUM_OF_STAGES(NUM_OF_STAGES)
  ) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (bus_ack),
    .q  (ack_s)
  );
`else
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);

  logic [CNT_W-1:0] cnt, cnt_n;

  // The acknowledge is not part of the timed protocol.
  logic          unused_ack;
  localparam int unused_stages = NUM_OF_STAGES;
  assign unused_ack = bus_ack;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
`ifndef BUS_SYNC_TX_ACK_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_n;
      unsync_bus <= bus_n;
      bus_enable <= enable_n;
`ifndef BUS_SYNC_TX_ACK_EN
      cnt        <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    bus_n    = unsync_bus;
    enable_n = bus_enable;
`ifndef BUS_SYNC_TX_ACK_EN
    cnt_n    = cnt;
`endif
    case (state)
      IDLE: begin
        // in_ready is only low in IDLE during reset, and reset wins in the register.
        if (in_valid) begin
          bus_n   = in_data;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        // Data has been stable for one cycle; now raise the enable.
        enable_n = 1'b1;
        state_n  = HOLD;
`ifndef BUS_SYNC_TX_ACK_EN
        cnt_n    = CNT_W'(HOLD_CYCLES - 1);
`endif
      end
      HOLD: begin
`ifdef BUS_SYNC_TX_ACK_EN
        if (ack_s) begin
          enable_n = 1'b0;
          state_n  = GAP;
        end
`else
        if (cnt == '0) begin
          enable_n = 1'b0;
          state_n  = GAP;
          cnt_n    = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
`endif
      end
      GAP: begin
`ifdef BUS_SYNC_TX_ACK_EN
        // Wait for the destination to release ack so the next word starts clean.
        if (!ack_s) begin
          state_n = IDLE;
        end
`else
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE) && !RST;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_bus_sync_tx.sv
// Self-checking bench for bus_sync_tx in timed mode with default parameters.
module tb_bus_sync_tx;

  localparam int H = 8;
  localparam int G = 8;
  localparam int P = 1 + H + G;  // cycles after accept before ready returns

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       bus_ack = 1'b0;
  logic       in_ready;
  logic [7:0] unsync_bus;
  logic       bus_enable;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  bus_sync_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .unsync_bus(unsync_bus),
    .bus_enable(bus_enable),
    .bus_ack   (bus_ack),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: tracks only "cycles since the last accepted word".
  int         cyc = 0;
  bit         active = 1'b0;
  int         k = 0;
  logic [7:0] m_bus = 8'h00;
  int         acc_cnt = 0;
  bit         checking = 1'b0;
  bit         m_ready;
  exp_t       sbq[$];

  always @(posedge CLK) begin
    m_ready = !RST && !(active && k < P);
    cyc++;
    if (RST) begin
      active   = 1'b0;
      k        = 0;
      m_bus    = 8'h00;
      sbq.delete();
      checking = 1'b1;
    end else if (in_valid && m_ready) begin
      active = 1'b1;
      k      = 0;
      m_bus  = in_data;
      acc_cnt++;
      sbq.push_back('{d: in_data, c: cyc});
    end else if (active && k < 1000) begin
      k++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: lockstep output check plus scoreboard pop on each enable rising edge.
  logic prev_en = 1'b0;
  bit   e_busy, e_en, e_ready;
  exp_t e;

  always @(negedge CLK) begin
    if (checking) begin
      e_busy  = active && k < P;
      e_en    = active && k >= 1 && k <= H;
      e_ready = !RST && !e_busy;
      check("in_ready",   32'(in_ready),   32'(e_ready));
      check("busy",       32'(busy),       32'(e_busy));
      check("bus_enable", 32'(bus_enable), 32'(e_en));
      check("unsync_bus", 32'(unsync_bus), 32'(m_bus));
      if (bus_enable === 1'b1 && prev_en !== 1'b1) begin
        if (sbq.size() == 0) begin
          check("spurious_rise", 32'(1), 32'(0));
        end else begin
          e = sbq.pop_front();
          check("rise_data",    32'(unsync_bus), 32'(e.d));
          check("rise_latency", 32'(cyc),        32'(e.c + 1));
        end
      end
      prev_en = bus_enable;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int start;
    int n;
    start    = acc_cnt;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      tick();
      n++;
    end while (acc_cnt == start && n < 100);
    if (acc_cnt == start) check("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset then idle
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    repeat (2) tick();

    // Single word
    send(8'hA5);
    repeat (20) tick();

    // Back-to-back with in_valid held
    send(8'h11);
    send(8'h22);
    repeat (20) tick();

    // Valid while busy is ignored
    send(8'h77);
    repeat (3) tick();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();

    // Reset in cycle 4 of HOLD
    send(8'h99);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (5) tick();

    // Randomized traffic with sporadic resets; bus_ack must have no effect
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(2) == 0);
      in_data  = 8'($urandom);
      bus_ack  = 1'($urandom);
      RST      = ($urandom_range(399) == 0);
      tick();
    end
    RST      = 1'b0;
    in_valid = 1'b0;
    repeat (25) tick();

    check("scoreboard_drained", 32'(sbq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
